count_sequence_checker: RTL and testbench

Downstream monitor for the random sequence counter. Samples the counter's 3-bit `count` output every enabled clock and locks onto a programmed 8-entry (or shorter) cyclic sequence. Once locked, it flags any deviation, counts errors, and counts completed sequence loops. It sits beside the controller on the same `count` bus, consumes only, and never drives the counter.

---
 rtl/count_sequence_checker.sv | 145 ++++++++++++++
 tb/tb_count_sequence_checker.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/count_sequence_checker.sv
// count_sequence_checker
// Passive monitor for the random sequence counter. It locks onto a programmed
// cyclic sequence of 3-bit values and then flags any deviation. It also counts
// mismatches (saturating) and completed loops (wrapping). Every output comes
// from registered state, so there is no combinational path from count.
module count_sequence_checker #(
    parameter logic [23:0] SEQ     = 24'h997358,
    parameter int          SEQ_LEN = 8,
    parameter int          LOOP_W  = 8
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic [2:0]        count,
    output logic              locked,
    output logic              error,
    output logic [7:0]        err_count,
    output logic [LOOP_W-1:0] loops,
    output logic [2:0]        expected
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_CONFIRM = 2'd1,
        S_LOCKED  = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    localparam logic [2:0] LAST = 3'(SEQ_LEN - 1);

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic              error_q, error_d;
    logic [7:0]        err_count_q, err_count_d;
    logic [LOOP_W-1:0] loops_q, loops_d;

    logic [7:0]        hit;
    logic              found;
    logic [2:0]        first_idx;
    logic              ptr_match;

    // Entry idx of the packed sequence.
    function automatic logic [2:0] seq_at(input logic [2:0] idx);
        return SEQ[3*int'(idx) +: 3];
    endfunction

    // Cyclic pointer advance over the valid entries only.
    function automatic logic [2:0] nxt(input logic [2:0] idx);
        return (idx == LAST) ? 3'd0 : idx + 3'd1;
    endfunction

    // Per-entry comparators; entries beyond SEQ_LEN never match.
    for (genvar gi = 0; gi < 8; gi++) begin : g_hit
        if (gi < SEQ_LEN) begin : g_valid
            assign hit[gi] = (SEQ[3*gi +: 3] == count);
        end else begin : g_unused
            assign hit[gi] = 1'b0;
        end
    end

    // Lowest-index match wins, so duplicate entries resolve deterministically.
    always_comb begin
        found     = 1'b0;
        first_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (hit[i]) begin
                found     = 1'b1;
                first_idx = 3'(i);
            end
        end
    end

    assign ptr_match = (count == seq_at(ptr_q));

    // Next-state logic; with en low everything holds and error drops.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        error_d     = 1'b0;
        err_count_d = err_count_q;
        loops_d     = loops_q;
        case (state_q)
            S_SEARCH: begin
                if (en && found) begin
                    ptr_d   = nxt(first_idx);
                    state_d = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (en) begin
                    if (ptr_match) begin
                        ptr_d   = nxt(ptr_q);
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_SEARCH;
                    end
                end
            end
            S_LOCKED: begin
                if (en) begin
                    if (ptr_match) begin
                        ptr_d = nxt(ptr_q);
                        if (ptr_q == LAST) begin
                            loops_d = loops_q + 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        state_d = S_SEARCH;
                    end
                end
            end
            default: begin
                // The unused encoding recovers unconditionally.
                state_d = S_SEARCH;
            end
        endcase
    end

    // State register with synchronous clear taking priority.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= S_SEARCH;
            ptr_q       <= 3'd0;
            error_q     <= 1'b0;
            err_count_q <= 8'd0;
            loops_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            error_q     <= error_d;
            err_count_q <= err_count_d;
            loops_q     <= loops_d;
        end
    end

    assign locked    = (state_q == S_LOCKED);
    assign error     = error_q;
    assign err_count = err_count_q;
    assign loops     = loops_q;
    assign expected  = locked ? seq_at(ptr_q) : 3'd0;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed bench for count_sequence_checker. A behavioural model predicts the
// outputs for each driven sample. The prediction is queued when the sample is
// driven and popped and compared one edge later.
module tb_count_sequence_checker;

    logic       clk;
    logic       clear;
    logic       en;
    logic [2:0] count;
    logic       locked;
    logic       error;
    logic [7:0] err_count;
    logic [7:0] loops;
    logic [2:0] expected;

    int checks = 0;
    int errors = 0;

    count_sequence_checker dut (
        .clk       (clk),
        .clear     (clear),
        .en        (en),
        .count     (count),
        .locked    (locked),
        .error     (error),
        .err_count (err_count),
        .loops     (loops),
        .expected  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       locked;
        logic       error;
        logic [7:0] err_count;
        logic [7:0] loops;
        logic [2:0] expected;
    } exp_t;

    exp_t sb_q[$];

    // Default sequence, listed in order: 0,3,5,1,7,2,6,4.
    int seq [8] = '{0, 3, 5, 1, 7, 2, 6, 4};

    // Model state: 0 = SEARCH, 1 = CONFIRM, 2 = LOCKED.
    int         m_state = 0;
    int         m_ptr   = 0;
    logic       m_error = 1'b0;
    logic [7:0] m_errc  = 8'd0;
    logic [7:0] m_loops = 8'd0;

    function automatic int m_next(input int i);
        return (i == 7) ? 0 : i + 1;
    endfunction

    task automatic model_step(input logic c_clr, input logic e, input logic [2:0] c);
        bit hit;
        if (c_clr) begin
            m_state = 0;
            m_ptr   = 0;
            m_error = 1'b0;
            m_errc  = 8'd0;
            m_loops = 8'd0;
        end else begin
            m_error = 1'b0;
            if (e) begin
                if (m_state == 0) begin
                    hit = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        if (!hit && seq[i] == int'(c)) begin
                            hit     = 1'b1;
                            m_ptr   = m_next(i);
                            m_state = 1;
                        end
                    end
                end else if (m_state == 1) begin
                    if (int'(c) == seq[m_ptr]) begin
                        m_ptr   = m_next(m_ptr);
                        m_state = 2;
                    end else begin
                        m_state = 0;
                    end
                end else begin
                    if (int'(c) == seq[m_ptr]) begin
                        if (m_ptr == 7) m_loops = m_loops + 8'd1;
                        m_ptr = m_next(m_ptr);
                    end else begin
                        m_error = 1'b1;
                        if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
                        m_state = 0;
                    end
                end
            end
        end
    endtask

    // Drive one sample, queue the prediction, and check just after the edge.
    task automatic step(input logic c_clr, input logic e, input logic [2:0] c,
                        input string tag, input bit quiet = 1'b0);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        clear = c_clr;
        en    = e;
        count = c;
        model_step(c_clr, e, c);
        ex.locked    = (m_state == 2);
        ex.error     = m_error;
        ex.err_count = m_errc;
        ex.loops     = m_loops;
        ex.expected  = (m_state == 2) ? 3'(seq[m_ptr]) : 3'd0;
        sb_q.push_back(ex);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        assert (locked === got.locked) else begin
            errors++;
            $error("FAIL %s locked: got %0b want %0b", tag, locked, got.locked);
        end
        checks++;
        assert (error === got.error) else begin
            errors++;
            $error("FAIL %s error: got %0b want %0b", tag, error, got.error);
        end
        checks++;
        assert (err_count === got.err_count) else begin
            errors++;
            $error("FAIL %s err_count: got %0d want %0d", tag, err_count, got.err_count);
        end
        checks++;
        assert (loops === got.loops) else begin
            errors++;
            $error("FAIL %s loops: got %0d want %0d", tag, loops, got.loops);
        end
        checks++;
        assert (expected === got.expected) else begin
            errors++;
            $error("FAIL %s expected: got %0d want %0d", tag, expected, got.expected);
        end
        if (!quiet)
            $display("step %-12s clr=%0b en=%0b count=%0d -> locked=%0b error=%0b err_count=%0d loops=%0d expected=%0d",
                     tag, c_clr, e, c, locked, error, err_count, loops, expected);
    endtask

    initial begin
        logic [2:0] loop_vals [10];
        loop_vals = '{3'd0, 3'd3, 3'd5, 3'd1, 3'd7, 3'd2, 3'd6, 3'd4, 3'd0, 3'd3};
        clear = 1'b1;
        en    = 1'b1;
        count = 3'd5;

        // Reset values.
        step(1'b1, 1'b1, 3'd5, "reset0");
        step(1'b1, 1'b1, 3'd5, "reset1");

        // Lock and a full loop.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, loop_vals[i], $sformatf("loop%0d", i));
            if (i == 1) begin
                checks++;
                assert (locked === 1'b1 && expected === 3'd5) else begin
                    errors++;
                    $error("FAIL lock_after_3: got locked=%0b expected=%0d want 1/5", locked, expected);
                end
            end
            if (i == 7) begin
                checks++;
                assert (loops === 8'd1) else begin
                    errors++;
                    $error("FAIL loop_count: got %0d want 1", loops);
                end
            end
        end

        // Advance to expected=7, then mismatch with 2.
        step(1'b0, 1'b1, 3'd5, "adv5");
        step(1'b0, 1'b1, 3'd1, "adv1");
        step(1'b0, 1'b1, 3'd2, "mismatch");
        checks++;
        assert (error === 1'b1 && err_count === 8'd1 && locked === 1'b0) else begin
            errors++;
            $error("FAIL mismatch_flags: got error=%0b err_count=%0d locked=%0b want 1/1/0",
                   error, err_count, locked);
        end
        step(1'b0, 1'b1, 3'd6, "relock6");
        step(1'b0, 1'b1, 3'd4, "relock4");

        // Failed confirm from SEARCH, then lock on 1,7.
        step(1'b1, 1'b0, 3'd0, "clr_search");
        step(1'b0, 1'b1, 3'd0, "fc0");
        step(1'b0, 1'b1, 3'd5, "fc5");
        step(1'b0, 1'b1, 3'd1, "fc1");
        step(1'b0, 1'b1, 3'd7, "fc7");

        // Enable gating with garbage on count.
        step(1'b0, 1'b0, 3'd0, "gate0");
        step(1'b0, 1'b0, 3'd0, "gate1");
        step(1'b0, 1'b0, 3'd5, "gate2");
        step(1'b0, 1'b1, 3'd2, "resume2");
        step(1'b0, 1'b1, 3'd6, "resume6");
        step(1'b0, 1'b1, 3'd4, "resume4");
        step(1'b0, 1'b1, 3'd0, "resume0");

        // Force a stream of mismatches to reach error-count saturation.
        step(1'b0, 1'b1, 3'd1, "brk");
        for (int i = 0; i < 260; i++) begin
            step(1'b0, 1'b1, 3'd0, "sat_a", 1'b1);
            step(1'b0, 1'b1, 3'd3, "sat_b", 1'b1);
            step(1'b0, 1'b1, 3'd0, "sat_miss", 1'b1);
        end
        $display("saturation loop done: err_count=%0d", err_count);
        checks++;
        assert (err_count === 8'd255) else begin
            errors++;
            $error("FAIL saturation: got %0d want 255", err_count);
        end

        // Lock, then clear mid-operation.
        step(1'b0, 1'b1, 3'd0, "pre_clr0");
        step(1'b0, 1'b1, 3'd3, "pre_clr3");
        step(1'b1, 1'b1, 3'd5, "midclear");
        step(1'b0, 1'b0, 3'd5, "post_clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
